toe_conn_init: RTL and testbench

//  TCP-offload-engine connection-setup block on a CPU-facing memory-mapped slave port.
//  - Open: software writes a connection tuple; the block checks for a duplicate,

---
 rtl/toe_pkg.sv | 31 +++
 rtl/toe_conn_table.sv | 40 ++++
 rtl/toe_conn_init.sv | 156 +++++++++++++++
 tb/tb_toe_conn_init.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/toe_pkg.sv
// Shared constants, command field positions, status codes and FSM states
// for the TOE connection-setup block.
package toe_pkg;
    localparam int N_CONN    = 16;
    localparam int ID_W      = $clog2(N_CONN);
    localparam int TUPLE_W   = 34;
    localparam int TUPLE_LSB = 8;
    localparam int NEW_LSB   = 0;
    localparam int KILL_LSB  = 2;
    localparam int KID_LSB   = 4;

    localparam logic [1:0] REQ_SET   = 2'b01;
    localparam logic [1:0] REQ_NONE  = 2'b00;

    localparam logic [1:0] DONE_NONE = 2'b00;
    localparam logic [1:0] DONE_OPEN = 2'b01;
    localparam logic [1:0] DONE_KILL = 2'b10;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_DUP   = 2'b01;
    localparam logic [1:0] ERR_FULL  = 2'b10;
    localparam logic [1:0] ERR_CMD   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEARCH,
        S_ALLOC,
        S_KILL,
        S_REPORT
    } state_t;
endpackage

// File: rtl/toe_conn_table.sv
// Connection table: tuple storage with one asynchronous read port for the
// search walk, one write port for allocation, and a resettable valid vector.
module toe_conn_table
    import toe_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [ID_W-1:0]    raddr,
    output logic [TUPLE_W-1:0] rdata,
    input  logic               we,
    input  logic [ID_W-1:0]    waddr,
    input  logic [TUPLE_W-1:0] wdata,
    input  logic               clr,
    input  logic [ID_W-1:0]    caddr,
    output logic [N_CONN-1:0]  valid
);
    logic [TUPLE_W-1:0] mem [N_CONN];

    // Storage is not reset; stale contents are masked by the valid vector.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else begin
            if (we) begin
                valid[waddr] <= 1'b1;
            end
            if (clr) begin
                valid[caddr] <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/toe_conn_init.sv
// TOE connection setup: accepts open/kill commands on a memory-mapped port,
// walks the table for duplicates and the lowest free ID, and reports status.
module toe_conn_init
    import toe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic        address,
    input  logic [63:0] writedata,
    output logic [31:0] readdata
);
    state_t             state, state_next;
    logic [ID_W-1:0]    idx, free_idx, kill_id_q, new_id;
    logic               found_free, existing;
    logic [TUPLE_W-1:0] tuple_q, rd_tuple;
    logic [N_CONN-1:0]  valid;
    logic [1:0]         done, error;
    logic               busy;
    logic               accept, cmd_open, cmd_kill, tbl_we, tbl_clr;
    logic [1:0]         new_req, kill_req;
    logic               read_unused;

    assign read_unused = read;
    assign new_req  = writedata[NEW_LSB +: 2];
    assign kill_req = writedata[KILL_LSB +: 2];
    assign cmd_open = (new_req == REQ_SET) && (kill_req == REQ_NONE);
    assign cmd_kill = (kill_req == REQ_SET) && (new_req == REQ_NONE);
    assign accept   = chipselect && write && !address && (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tbl_we     = 1'b0;
        tbl_clr    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && cmd_open) begin
                    state_next = S_SEARCH;
                end else if (accept && cmd_kill) begin
                    state_next = S_KILL;
                end
            end
            S_SEARCH: begin
                if (idx == ID_W'(N_CONN - 1)) begin
                    state_next = S_ALLOC;
                end
            end
            S_ALLOC: begin
                tbl_we     = !existing && found_free;
                state_next = S_REPORT;
            end
            S_KILL: begin
                tbl_clr    = valid[kill_id_q];
                state_next = S_REPORT;
            end
            S_REPORT: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            free_idx   <= '0;
            kill_id_q  <= '0;
            new_id     <= '0;
            found_free <= 1'b0;
            existing   <= 1'b0;
            tuple_q    <= '0;
            done       <= DONE_NONE;
            error      <= ERR_NONE;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        tuple_q    <= writedata[TUPLE_LSB +: TUPLE_W];
                        kill_id_q  <= writedata[KID_LSB +: ID_W];
                        idx        <= '0;
                        found_free <= 1'b0;
                        existing   <= 1'b0;
                        done       <= DONE_NONE;
                        if (cmd_open || cmd_kill) begin
                            error <= ERR_NONE;
                            busy  <= 1'b1;
                        end else begin
                            error <= ERR_CMD;
                            busy  <= 1'b0;
                        end
                    end
                end
                S_SEARCH: begin
                    if (valid[idx] && (rd_tuple == tuple_q)) begin
                        existing <= 1'b1;
                    end
                    // First free slot seen during the ascending walk is the lowest.
                    if (!valid[idx] && !found_free) begin
                        found_free <= 1'b1;
                        free_idx   <= idx;
                    end
                    idx <= idx + ID_W'(1);
                end
                S_ALLOC: begin
                    if (existing) begin
                        error <= ERR_DUP;
                    end else if (!found_free) begin
                        error <= ERR_FULL;
                    end else begin
                        new_id <= free_idx;
                        done   <= DONE_OPEN;
                    end
                end
                S_KILL: begin
                    if (valid[kill_id_q]) begin
                        done <= DONE_KILL;
                    end else begin
                        error <= ERR_CMD;
                    end
                end
                S_REPORT: busy <= 1'b0;
                default:  busy <= 1'b0;
            endcase
        end
    end

    toe_conn_table u_table (
        .clk   (clk),
        .reset (reset),
        .raddr (idx),
        .rdata (rd_tuple),
        .we    (tbl_we),
        .waddr (free_idx),
        .wdata (tuple_q),
        .clr   (tbl_clr),
        .caddr (kill_id_q),
        .valid (valid)
    );

    always_comb begin
        if (address) begin
            readdata = {16'b0, valid};
        end else begin
            readdata = {23'b0, busy, error, done, new_id};
        end
    end
endmodule

// File: tb/tb_toe_conn_init.sv
// Directed bench for toe_conn_init: open/kill/duplicate/full/bad-command
// sequences with hand-computed status words and latencies.
module tb_toe_conn_init;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic        address = 1'b0;
    logic [63:0] writedata = '0;
    logic [31:0] readdata;

    int total = 0;
    int bad = 0;

    toe_conn_init dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata)
    );

    always #5 clk = ~clk;

    localparam logic [33:0] T1 = 34'h1_2345_6789;
    localparam logic [33:0] T2 = 34'h1_2345_678A;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_open(input logic [33:0] t);
        return {22'b0, t, 4'h0, 2'b00, 2'b01};
    endfunction

    function automatic logic [63:0] mk_kill(input logic [3:0] id);
        return {56'b0, id, 2'b01, 2'b00};
    endfunction

    task automatic rd(input logic a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
        address = 1'b0;
        #1;
    endtask

    // Issue a command and count cycles after the accepting edge until BUSY drops.
    task automatic do_cmd(input string tag, input logic [63:0] d, input int lat);
        int n;
        @(negedge clk);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 1'b0;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write      = 1'b0;
        n = 0;
        while (readdata[8] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, n, lat);
    endtask

    task automatic chk_status(input string tag, input logic [31:0] exp);
        logic [31:0] d;
        rd(1'b0, d);
        chk({tag, "_status"}, d, exp);
    endtask

    task automatic chk_map(input string tag, input logic [31:0] exp);
        logic [31:0] d;
        rd(1'b1, d);
        chk({tag, "_map"}, d, exp);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_status("reset", 32'h0);
        chk_map("reset", 32'h0);

        do_cmd("open_t1", mk_open(T1), 18);
        chk_status("open_t1", 32'h010);
        chk_map("open_t1", 32'h0001);

        do_cmd("dup_t1", mk_open(T1), 18);
        chk_status("dup_t1", 32'h040);
        do_cmd("open_t2", mk_open(T2), 18);
        chk_status("open_t2", 32'h011);
        chk_map("open_t2", 32'h0003);

        do_cmd("kill0", mk_kill(4'd0), 2);
        chk_status("kill0", 32'h021);
        chk_map("kill0", 32'h0002);
        do_cmd("kill0_again", mk_kill(4'd0), 2);
        chk_status("kill0_again", 32'h0C1);

        // Slot 0 is free again, then 2..15 fill in ascending order.
        for (int i = 0; i < 15; i++) begin
            logic [3:0] eid;
            eid = (i == 0) ? 4'd0 : 4'(i + 1);
            do_cmd("fill", mk_open(34'h2_0000_0000 + 34'(i)), 18);
            chk_status("fill", {27'b0, 1'b0, 4'h0, 2'b01, eid} & 32'h3FF | 32'h010 & 32'h0 | {22'b0, 2'b00, 2'b01, eid});
        end
        chk_map("full", 32'hFFFF);
        do_cmd("open17", mk_open(34'h3_0000_0000), 18);
        chk_status("open17", 32'h08F);
        do_cmd("kill5", mk_kill(4'd5), 2);
        chk_status("kill5", 32'h02F);
        chk_map("kill5", 32'hFFDF);
        do_cmd("reopen5", mk_open(34'h3_0000_0005), 18);
        chk_status("reopen5", 32'h015);
        chk_map("reopen5", 32'hFFFF);

        do_cmd("both", {56'b0, 4'h0, 2'b01, 2'b01}, 0);
        chk_status("both", 32'h0C5);
        do_cmd("newreq10", {56'b0, 4'h0, 2'b00, 2'b10}, 0);
        chk_status("newreq10", 32'h0C5);
        chk_map("bad_cmd", 32'hFFFF);

        // Kill ID 3, then attempt to kill ID 4 while the first is in flight.
        @(negedge clk);
        chipselect = 1'b1;
        write      = 1'b1;
        writedata  = mk_kill(4'd3);
        @(negedge clk);
        writedata  = mk_kill(4'd4);
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_status("busy_wr", 32'h025);
        chk_map("busy_wr", 32'hFFF7);

        // Reset in the middle of a search walk.
        @(negedge clk);
        chipselect = 1'b1;
        write      = 1'b1;
        writedata  = mk_open(34'h3_0000_0077);
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_map("mid_reset", 32'h0);
        chk_status("mid_reset", 32'h0);
        do_cmd("after_reset", mk_open(T2), 18);
        chk_status("after_reset", 32'h010);
        chk_map("after_reset", 32'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
